// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read-master channel between two burst requesters.
// Grants whole bursts, pulses init with the captured address, steers beats to the owner and checks burst length.
module axi_read_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BURST_LEN     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_i,
  input  logic [ADDRESS_WIDTH-1:0] addr0_i,
  output logic                     gnt0_o,
  output logic [DATA_WIDTH-1:0]    data0_o,
  output logic                     valid0_o,
  output logic                     last0_o,
  input  logic                     ready0_i,
  input  logic                     req1_i,
  input  logic [ADDRESS_WIDTH-1:0] addr1_i,
  output logic                     gnt1_o,
  output logic [DATA_WIDTH-1:0]    data1_o,
  output logic                     valid1_o,
  output logic                     last1_o,
  input  logic                     ready1_i,
  output logic                     axi_read_init_o,
  output logic [ADDRESS_WIDTH-1:0] axi_read_address_o,
  input  logic [DATA_WIDTH-1:0]    axi_read_data_i,
  input  logic                     axi_read_valid_i,
  input  logic                     axi_read_last_i,
  output logic                     axi_read_ready_o,
  output logic                     busy_o,
  output logic                     err_o
);

  // Counter is wide enough to count past BURST_LEN so an overlong burst is still visible.
  localparam int CNT_W = $clog2(BURST_LEN + 2);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DATA
  } state_t;

  state_t                   state_reg, state_next;
  logic                     owner_reg, owner_next;
  logic                     last_owner_reg, last_owner_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]         beat_cnt_reg, beat_cnt_next;
  logic                     err_reg, err_next;

  logic [1:0]               req;
  logic [1:0]               ready;
  logic [1:0]               gnt;
  logic [1:0]               valid;
  logic [1:0]               last;
  logic [ADDRESS_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0]    data [2];

  logic                     winner;
  logic                     xfer;
  logic                     init;
  logic                     axi_ready;
  logic [CNT_W-1:0]         cnt_plus;

  assign req     = {req1_i, req0_i};
  assign ready   = {ready1_i, ready0_i};
  assign addr[0] = addr0_i;
  assign addr[1] = addr1_i;

  // Per-requester steering: only the owner sees valid/last; data is gated to zero outside DATA.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign gnt[gi]   = (state_reg == INIT) && (owner_reg == 1'(gi));
      assign valid[gi] = (state_reg == DATA) && (owner_reg == 1'(gi)) && axi_read_valid_i;
      assign last[gi]  = (state_reg == DATA) && (owner_reg == 1'(gi)) && axi_read_last_i;
      assign data[gi]  = (state_reg == DATA) ? axi_read_data_i : '0;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    addr_next       = addr_reg;
    beat_cnt_next   = beat_cnt_reg;
    err_next        = err_reg;
    init            = 1'b0;
    axi_ready       = 1'b0;
    xfer            = 1'b0;
    cnt_plus        = beat_cnt_reg + 1'b1;
    // On a tie the requester that did not own the previous burst wins.
    winner          = (req[0] && req[1]) ? ~last_owner_reg : req[1];

    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next      = winner;
          last_owner_next = winner;
          addr_next       = addr[winner];
          state_next      = INIT;
        end
      end
      INIT: begin
        init          = 1'b1;
        beat_cnt_next = '0;
        state_next    = DATA;
      end
      DATA: begin
        axi_ready = ready[owner_reg];
        xfer      = axi_read_valid_i && axi_ready;
        if (xfer) begin
          if (beat_cnt_reg != '1) begin
            beat_cnt_next = cnt_plus;
          end
          if (axi_read_last_i) begin
            if (cnt_plus != BURST_CNT) begin
              err_next = 1'b1;
            end
            state_next = IDLE;
          end else if (cnt_plus == BURST_CNT) begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      addr_reg       <= '0;
      beat_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      addr_reg       <= addr_next;
      beat_cnt_reg   <= beat_cnt_next;
      err_reg        <= err_next;
    end
  end

  assign gnt0_o             = gnt[0];
  assign gnt1_o             = gnt[1];
  assign valid0_o           = valid[0];
  assign valid1_o           = valid[1];
  assign last0_o            = last[0];
  assign last1_o            = last[1];
  assign data0_o            = data[0];
  assign data1_o            = data[1];
  assign axi_read_init_o    = init;
  assign axi_read_ready_o   = axi_ready;
  assign axi_read_address_o = addr_reg;
  assign busy_o             = (state_reg != IDLE);
  assign err_o              = err_reg;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a table of burst records plus hand-written reset sequences.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, ready0, ready1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, valid0, valid1, last0, last1;
  logic [63:0] data0, data1;
  logic        axi_read_init_o, axi_read_ready_o, busy, err;
  logic [31:0] axi_read_address_o;
  logic [63:0] axi_data;
  logic        axi_valid, axi_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.DATA_WIDTH(64), .ADDRESS_WIDTH(32), .BURST_LEN(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_i            (req0),
    .addr0_i           (addr0),
    .gnt0_o            (gnt0),
    .data0_o           (data0),
    .valid0_o          (valid0),
    .last0_o           (last0),
    .ready0_i          (ready0),
    .req1_i            (req1),
    .addr1_i           (addr1),
    .gnt1_o            (gnt1),
    .data1_o           (data1),
    .valid1_o          (valid1),
    .last1_o           (last1),
    .ready1_i          (ready1),
    .axi_read_init_o   (axi_read_init_o),
    .axi_read_address_o(axi_read_address_o),
    .axi_read_data_i   (axi_data),
    .axi_read_valid_i  (axi_valid),
    .axi_read_last_i   (axi_last),
    .axi_read_ready_o  (axi_read_ready_o),
    .busy_o            (busy),
    .err_o             (err)
  );

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        hold;      // keep both reqs high through the burst
    int          owner;
    logic [31:0] exp_addr;
    int          exp_wait;  // negedges from req drive to init
    int          nbeats;    // beat carrying last
    logic [15:0] stall;     // beat i held back one cycle by owner ready
    logic        err_in, err_out;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic r0, logic r1, logic [31:0] a0, logic [31:0] a1, logic hold,
                              int owner, logic [31:0] exp_addr, int exp_wait, int nbeats,
                              logic [15:0] stall, logic err_in, logic err_out);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.hold = hold;
    v.owner = owner; v.exp_addr = exp_addr; v.exp_wait = exp_wait; v.nbeats = nbeats;
    v.stall = stall; v.err_in = err_in; v.err_out = err_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (axi_read_init_o) begin
        n = i;
        break;
      end
    end
  endtask

  // Drives beats after the INIT cycle; stop_at >= 0 asserts reset while that beat is offered.
  task automatic run_beats(input int k, input int own, input int nbeats, input logic [15:0] stall_mask,
                           input logic hold, input logic [31:0] exp_addr, input logic err_in,
                           input int stop_at);
    int          beat;
    logic        stalled;
    logic        stall;
    logic [63:0] d;
    beat    = 0;
    stalled = 1'b0;
    for (int t = 0; t < 64 && beat < nbeats; t++) begin
      @(posedge clk); #1;
      if (!hold) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      stall     = stall_mask[beat] && !stalled;
      d         = 64'(k * 256 + beat);
      axi_valid = 1'b1;
      axi_data  = d;
      axi_last  = (beat == nbeats - 1);
      if (own == 0) begin
        ready0 = !stall;
        ready1 = stall;
      end else begin
        ready1 = !stall;
        ready0 = stall;
      end
      if (beat == stop_at) rst = 1'b0;
      @(negedge clk);
      if (t == 0) chk("init_gnt_one_cycle", {axi_read_init_o, gnt0, gnt1}, 3'b000);
      chk("axi_ready", axi_read_ready_o, !stall);
      chk("valid_owner", (own == 0) ? valid0 : valid1, 1'b1);
      chk("valid_other", (own == 0) ? valid1 : valid0, 1'b0);
      chk("data_owner", (own == 0) ? data0 : data1, d);
      chk("last_owner", (own == 0) ? last0 : last1, beat == nbeats - 1);
      chk("last_other", (own == 0) ? last1 : last0, 1'b0);
      chk("address_hold", axi_read_address_o, exp_addr);
      chk("busy_data", busy, 1'b1);
      chk("err_during", err, err_in);
      if (beat == stop_at) return;
      if (stall) begin
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
        beat++;
      end
    end
  endtask

  task automatic run_entry(input int k);
    vec_t v;
    int   n;
    v = tbl[k];
    @(posedge clk); #1;
    rst       = 1'b1;
    req0      = v.r0;
    req1      = v.r1;
    addr0     = v.a0;
    addr1     = v.a1;
    axi_valid = 1'b0;
    axi_last  = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    wait_init(n);
    chk("init_latency", n, v.exp_wait);
    if (n == 0) return;
    chk("gnt0", gnt0, v.owner == 0);
    chk("gnt1", gnt1, v.owner == 1);
    chk("address", axi_read_address_o, v.exp_addr);
    chk("busy_init", busy, 1'b1);
    chk("err_init", err, v.err_in);
    run_beats(k, v.owner, v.nbeats, v.stall, v.hold, v.exp_addr, v.err_in, -1);
    @(posedge clk); #1;
    axi_valid = 1'b0;
    axi_last  = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("err_after", err, v.err_out);
    chk("valid_after", {valid0, valid1}, 2'b00);
    $display("burst %0d: owner=%0d addr=%08h beats=%0d err=%0b", k, v.owner, v.exp_addr, v.nbeats, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = mk(1, 0, 32'h2000, 32'h0,    0, 0, 32'h2000, 2, 16, 16'h0000, 0, 0);
    tbl[1] = mk(0, 1, 32'h0,    32'h1000, 0, 1, 32'h1000, 2, 16, 16'h0000, 0, 0);
    tbl[2] = mk(1, 1, 32'h4000, 32'h5000, 1, 0, 32'h4000, 2, 16, 16'h0000, 0, 0);
    tbl[3] = mk(1, 1, 32'h4000, 32'h5000, 1, 1, 32'h5000, 1, 16, 16'h0000, 0, 0);
    tbl[4] = mk(1, 1, 32'h4000, 32'h5000, 1, 0, 32'h4000, 1, 16, 16'h0000, 0, 0);
    tbl[5] = mk(1, 1, 32'h4000, 32'h5000, 0, 1, 32'h5000, 1, 16, 16'h0000, 0, 0);
    tbl[6] = mk(1, 0, 32'h3000, 32'h0,    0, 0, 32'h3000, 2, 16, 16'h001C, 0, 0);
    tbl[7] = mk(0, 1, 32'h0,    32'h6000, 0, 1, 32'h6000, 2, 12, 16'h0000, 0, 1);
    tbl[8] = mk(1, 0, 32'h7000, 32'h0,    0, 0, 32'h7000, 2, 16, 16'h0000, 1, 1);
    tbl[9] = mk(1, 0, 32'h9000, 32'h0,    0, 0, 32'h9000, 2, 16, 16'h0000, 0, 0);

    // Reset held with every input active: all outputs must stay at zero.
    rst       = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    addr0     = 32'h1111;
    addr1     = 32'h2222;
    ready0    = 1'b1;
    ready1    = 1'b1;
    axi_valid = 1'b1;
    axi_last  = 1'b1;
    axi_data  = 64'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctrl_zero", {gnt0, gnt1, axi_read_init_o, valid0, valid1, last0, last1, axi_read_ready_o}, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_address", axi_read_address_o, 32'h0);
      chk("rst_data", data0 | data1, 64'h0);
    end
    $display("reset: outputs checked for 3 cycles");

    for (int k = 0; k < 9; k++) run_entry(k);

    // Reset during the seventh beat of a burst, then a fresh burst must run normally.
    @(posedge clk); #1;
    req1  = 1'b1;
    addr1 = 32'h8000;
    wait_init(n);
    chk("mb_init_latency", n, 2);
    chk("mb_gnt1", gnt1, 1'b1);
    run_beats(10, 1, 16, 16'h0000, 1'b0, 32'h8000, 1'b1, 6);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mb_ctrl_zero", {gnt0, gnt1, axi_read_init_o, valid0, valid1, last0, last1, axi_read_ready_o}, 8'h00);
    chk("mb_busy", busy, 1'b0);
    chk("mb_err_cleared", err, 1'b0);
    chk("mb_address", axi_read_address_o, 32'h0);
    chk("mb_data", data0 | data1, 64'h0);
    $display("reset mid-burst: outputs checked");

    run_entry(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
